instr_fetch_unit: RTL and testbench

Instruction-side sequencer that supplies the control unit with its instruction word. Owns the program counter, fetches 32-bit words from instruction memory over a req/ack handshake, and presents a registered `IR` with a valid flag. It then waits for the control unit to finish the instruction and applies the control unit's next-PC selection (hold, +4, jump, register).

---
 rtl/instr_fetch_unit.sv | 113 +++++++++++
 tb/tb_instr_fetch_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the program counter, fetches 32-bit instruction
// words over a req/ack handshake and holds a registered IR with a valid
// flag until the control unit signals completion via `advance`.
//
// Handshake: `mem_req` is registered and stays high with `mem_addr` stable
// until a cycle in which `mem_ack` is high; `mem_rdata` is taken in that same
// cycle. `mem_ack` has no effect outside FETCH or while `mem_req` is low.
module instr_fetch_unit #(
    parameter int ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        pc_sel,
    input  logic [ADDR_W-1:0] jump_offset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              advance,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       IR,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    localparam logic [1:0] PC_HOLD  = 2'b00;
    localparam logic [1:0] PC_PLUS4 = 2'b01;
    localparam logic [1:0] PC_JUMP  = 2'b10;
    localparam logic [1:0] PC_IN    = 2'b11;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_ir;
    logic              r_ir_valid;
    logic              r_mem_req;

    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_pc_jump;
    logic [ADDR_W-1:0] w_pc_reg;

    // Candidate next-PC values; all arithmetic wraps modulo 2^ADDR_W.
    always_comb begin
        w_pc_plus4 = r_pc + ADDR_W'(4);
        w_pc_jump  = r_pc + jump_offset;
        w_pc_reg   = pc_in & ~ADDR_W'(3);
    end

    // Sequencer: reset -> fetch -> execute, with registered handshake outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_RST;
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
            r_mem_req  <= 1'b0;
        end else begin
            case (r_state)
                ST_RST: begin
                    r_state   <= ST_FETCH;
                    r_mem_req <= 1'b1;
                end
                ST_FETCH: begin
                    // advance is deliberately not looked at here.
                    if (r_mem_req && mem_ack) begin
                        r_ir       <= mem_rdata;
                        r_ir_valid <= 1'b1;
                        r_mem_req  <= 1'b0;
                        r_state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (advance && (pc_sel != PC_HOLD)) begin
                        case (pc_sel)
                            PC_PLUS4: r_pc <= w_pc_plus4;
                            PC_JUMP:  r_pc <= w_pc_jump;
                            PC_IN:    r_pc <= w_pc_reg;
                            default:  r_pc <= r_pc;
                        endcase
                        r_ir_valid <= 1'b0;
                        r_mem_req  <= 1'b1;
                        r_state    <= ST_FETCH;
                    end
                end
                default: begin
                    r_state    <= ST_RST;
                    r_ir_valid <= 1'b0;
                    r_mem_req  <= 1'b0;
                end
            endcase
        end
    end

    // Output mapping; the fetch address is always the current PC.
    always_comb begin
        mem_addr  = r_pc;
        mem_req   = r_mem_req;
        IR        = r_ir;
        ir_valid  = r_ir_valid;
        pc        = r_pc;
        pc_plus4  = w_pc_plus4;
        dbg_state = r_state;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a table of next-PC vectors replayed
// from EXEC, plus hand-written sequences for hold, wait states, advance
// during fetch and reset mid-fetch.
module tb_instr_fetch_unit;

  localparam int AW = 64;
  localparam logic [1:0] PC_HOLD  = 2'b00;
  localparam logic [1:0] PC_PLUS4 = 2'b01;
  localparam logic [1:0] PC_JUMP  = 2'b10;
  localparam logic [1:0] PC_IN    = 2'b11;

  logic          clock;
  logic          reset;
  logic [1:0]    pc_sel;
  logic [AW-1:0] jump_offset;
  logic [AW-1:0] pc_in;
  logic          advance;
  logic [AW-1:0] mem_addr;
  logic          mem_req;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic [31:0]   IR;
  logic          ir_valid;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_plus4;
  logic [1:0]    dbg_state;

  logic          ack_en;
  logic          ack_force;
  logic [31:0]   mem_word;

  int n_checks;
  int n_pass;

  typedef struct {
    logic [1:0]    sel;
    logic [AW-1:0] off;
    logic [AW-1:0] pin;
    logic [AW-1:0] exp_pc;
    logic [31:0]   word;
  } vec_t;

  vec_t vecs[10];

  instr_fetch_unit #(.ADDR_W(AW), .RESET_PC('0)) dut (
    .clock(clock), .reset(reset), .pc_sel(pc_sel), .jump_offset(jump_offset),
    .pc_in(pc_in), .advance(advance), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .IR(IR), .ir_valid(ir_valid),
    .pc(pc), .pc_plus4(pc_plus4), .dbg_state(dbg_state)
  );

  // clock / memory model
  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign mem_ack   = ack_force | (mem_req & ack_en);
  assign mem_rdata = mem_word;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // driver: pulse advance for one edge with the given selection
  task automatic do_advance(input logic [1:0] sel, input logic [AW-1:0] off, input logic [AW-1:0] pin);
    pc_sel = sel; jump_offset = off; pc_in = pin; advance = 1'b1;
    tick();
    advance = 1'b0;
  endtask

  logic [AW-1:0] hold_pc;
  logic [31:0]   hold_ir;

  initial begin
    n_checks = 0; n_pass = 0;
    reset = 1'b0; advance = 1'b0; pc_sel = PC_HOLD; jump_offset = '0; pc_in = '0;
    ack_en = 1'b1; ack_force = 1'b0; mem_word = 32'hAA0003E3;

    vecs[0] = '{PC_PLUS4, 64'd0, 64'd0, 64'd4, 32'h8B010000};
    vecs[1] = '{PC_PLUS4, 64'd0, 64'd0, 64'd8, 32'h8B010000};
    vecs[2] = '{PC_PLUS4, 64'd0, 64'd0, 64'd12, 32'h8B010000};
    vecs[3] = '{PC_IN, 64'd0, 64'h103, 64'h100, 32'h11111111};
    vecs[4] = '{PC_JUMP, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'hF8, 32'h22222222};
    vecs[5] = '{PC_IN, 64'd0, 64'h203, 64'h200, 32'h33333333};
    vecs[6] = '{PC_IN, 64'd0, 64'h0, 64'h0, 32'h44444444};
    vecs[7] = '{PC_JUMP, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h55555555};
    vecs[8] = '{PC_PLUS4, 64'd0, 64'd0, 64'd0, 32'h66666666};
    vecs[9] = '{PC_JUMP, 64'h40, 64'hFFF, 64'h40, 32'h77777777};

    // reset held for 3 cycles
    repeat (3) tick();
    check("rst_pc", pc, 0);
    check("rst_ir", IR, 0);
    check("rst_ir_valid", ir_valid, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_state", dbg_state, 0);

    reset = 1'b1;
    tick();
    check("rel_mem_req", mem_req, 1);
    check("rel_mem_addr", mem_addr, 0);
    check("rel_ir_valid", ir_valid, 0);
    tick();
    check("first_ir", IR, 32'hAA0003E3);
    check("first_ir_valid", ir_valid, 1);
    check("first_pc_plus4", pc_plus4, 4);
    check("first_mem_req", mem_req, 0);

    // table: one advance, one zero-wait fetch per record
    for (int i = 0; i < 10; i++) begin
      hold_ir = IR;
      mem_word = vecs[i].word;
      do_advance(vecs[i].sel, vecs[i].off, vecs[i].pin);
      check($sformatf("v%0d_bubble", i), ir_valid, 0);
      check($sformatf("v%0d_req", i), mem_req, 1);
      check($sformatf("v%0d_addr", i), mem_addr, vecs[i].exp_pc);
      check($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("v%0d_ir_kept", i), IR, hold_ir);
      tick();
      check($sformatf("v%0d_ir", i), IR, vecs[i].word);
      check($sformatf("v%0d_valid", i), ir_valid, 1);
      check($sformatf("v%0d_plus4", i), pc_plus4, vecs[i].exp_pc + 64'd4);
    end

    // hold: nothing changes, no refetch
    hold_pc = pc; hold_ir = IR;
    do_advance(PC_HOLD, 64'h100, 64'h300);
    for (int c = 0; c < 5; c++) begin
      check("hold_req", mem_req, 0);
      check("hold_pc", pc, hold_pc);
      check("hold_ir", IR, hold_ir);
      check("hold_valid", ir_valid, 1);
      tick();
    end

    // wait states with an ignored advance during fetch
    ack_en = 1'b0; mem_word = 32'hCAFEF00D;
    do_advance(PC_PLUS4, 64'd0, 64'd0);
    for (int c = 0; c < 4; c++) begin
      check("ws_req", mem_req, 1);
      check("ws_addr", mem_addr, 64'h44);
      check("ws_valid", ir_valid, 0);
      if (c == 1) do_advance(PC_JUMP, 64'h1000, 64'd0);
      else tick();
    end
    check("ws_pc_after_adv", pc, 64'h44);
    // ack and advance together: the advance is dropped
    ack_en = 1'b1;
    do_advance(PC_PLUS4, 64'd0, 64'd0);
    check("ws_ir", IR, 32'hCAFEF00D);
    check("ws_valid_done", ir_valid, 1);
    check("ws_pc_kept", pc, 64'h44);
    check("ws_state_exec", dbg_state, 2);
    tick();
    check("ws_no_refetch", mem_req, 0);
    check("ws_pc_still", pc, 64'h44);

    // reset mid-fetch, late ack discarded
    ack_en = 1'b0;
    do_advance(PC_PLUS4, 64'd0, 64'd0);
    check("mf_req", mem_req, 1);
    check("mf_addr", mem_addr, 64'h48);
    reset = 1'b0;
    #1;
    check("mf_req_drop", mem_req, 0);
    check("mf_pc", pc, 0);
    check("mf_ir_clr", IR, 0);
    check("mf_state", dbg_state, 0);
    ack_force = 1'b1; mem_word = 32'hDEADBEEF;
    tick();
    tick();
    check("mf_late_ir", IR, 0);
    check("mf_late_valid", ir_valid, 0);
    ack_force = 1'b0; ack_en = 1'b1; mem_word = 32'h12345678;
    reset = 1'b1;
    tick();
    check("mf_rel_req", mem_req, 1);
    check("mf_rel_addr", mem_addr, 0);
    tick();
    check("mf_rel_ir", IR, 32'h12345678);
    check("mf_rel_valid", ir_valid, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
